handshake_receiver: RTL and testbench



---
 rtl/handshake_pkg.sv | 12 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/handshake_receiver.sv | 87 ++++++++
 tb/tb_handshake_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types and default sizes for the handshake receive path and its sibling stages.
package handshake_pkg;

    localparam int unsigned HS_WIDTH = 8;
    localparam int unsigned HS_DEPTH = 4;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_ACK  = 2'd1
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes into a full FIFO and pops from an empty one
// are ignored.
module sync_fifo
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH = HS_WIDTH,
    parameter int unsigned DEPTH = HS_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full and empty come from the registered level, so a same-cycle pop never frees room
    // for a same-cycle push.
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/handshake_receiver.sv
// Four-phase request/acknowledge receiver: captures one word per rising request into a FIFO,
// withholds the acknowledge while full, and flags a request that is never released.
module handshake_receiver
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH   = HS_WIDTH,
    parameter int unsigned DEPTH   = HS_DEPTH,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     devA,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     devB,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rx_count,
    output logic                     err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);

    rx_state_t     state;
    logic [TW-1:0] tcnt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign push      = (state == RX_IDLE) && devA && !full;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RX_IDLE;
            devB     <= 1'b0;
            tcnt     <= '0;
            rx_count <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (push) begin
                        state <= RX_ACK;
                        devB  <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                RX_ACK: begin
                    if (!devA) begin
                        state    <= RX_IDLE;
                        devB     <= 1'b0;
                        rx_count <= rx_count + 8'd1;
                    end else begin
                        if (tcnt != T_LIMIT) tcnt <= tcnt + 1'b1;
                        // This edge brings the count to the limit (or it is already there).
                        if (tcnt >= T_LIMIT - 1'b1) err <= 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    devB  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_receiver.sv
// Directed and randomized stimulus for handshake_receiver against a queue-based reference model.
module tb_handshake_receiver;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    devA;
    logic [WIDTH-1:0]        data_in;
    logic                    devB;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  level;
    logic [7:0]              rx_count;
    logic                    err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [WIDTH-1:0] q[$];
    bit             m_ack;
    bit             m_err;
    int             m_hold;
    int             m_rx;

    always #5 clk = ~clk;

    handshake_receiver #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .devA      (devA),
        .data_in   (data_in),
        .devB      (devB),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .rx_count  (rx_count),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the current inputs, then compare after the edge.
    task automatic step();
        bit pop_m;
        bit push_m;
        if (!reset) begin
            q.delete();
            m_ack  = 0;
            m_err  = 0;
            m_hold = 0;
            m_rx   = 0;
        end else begin
            pop_m  = (q.size() > 0) && out_ready;
            push_m = !m_ack && devA && (q.size() < DEPTH);
            if (m_ack) begin
                if (!devA) begin
                    m_ack = 0;
                    m_rx  = (m_rx + 1) % 256;
                end else begin
                    m_hold++;
                    if (m_hold >= TIMEOUT) m_err = 1;
                end
            end
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back(data_in);
                m_ack  = 1;
                m_hold = 0;
            end
        end
        @(negedge clk);
        check("devB", 32'(devB), 32'(m_ack));
        check("level", 32'(level), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
        check("rx_count", 32'(rx_count), 32'(m_rx));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic hs(input logic [WIDTH-1:0] d);
        devA    = 1'b1;
        data_in = d;
        step();
        devA = 1'b0;
        step();
    endtask

    initial begin
        int hold_target;
        int held;
        int rx_base;

        reset     = 1'b0;
        devA      = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        check("reset_level", 32'(level), 32'd0);
        check("reset_devB", 32'(devB), 32'd0);
        reset = 1'b1;

        // Single transfer
        devA    = 1'b1;
        data_in = 8'hA5;
        step();
        check("single_devB_hi", 32'(devB), 32'd1);
        devA = 1'b0;
        step();
        check("single_devB_lo", 32'(devB), 32'd0);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_rx", 32'(rx_count), 32'd1);
        check("single_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Fill to full, fifth request stalls until one pop
        for (int i = 1; i <= 4; i++) hs(8'(i));
        devA    = 1'b1;
        data_in = 8'h05;
        for (int i = 0; i < 3; i++) step();
        check("full_devB", 32'(devB), 32'd0);
        check("full_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_pop_devB", 32'(devB), 32'd0);
        step();
        check("full_resume_devB", 32'(devB), 32'd1);
        devA = 1'b0;
        step();
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("drain_order", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;

        // Simultaneous push and pop at level 2
        hs(8'h10);
        hs(8'h11);
        devA      = 1'b1;
        data_in   = 8'h12;
        out_ready = 1'b1;
        step();
        check("pushpop_level", 32'(level), 32'd2);
        devA      = 1'b0;
        out_ready = 1'b0;
        step();
        check("pushpop_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        check("pushpop_next", 32'(out_data), 32'h12);
        step();

        // Pointer wrap with the consumer always ready
        rx_base = int'(rx_count);
        for (int i = 0; i < 10; i++) hs(8'(8'h40 + i));
        check("wrap_rx", 32'(rx_count), 32'((rx_base + 10) % 256));
        out_ready = 1'b0;

        // Timeout on a request that is never released
        devA    = 1'b1;
        data_in = 8'h77;
        step();
        for (int k = 1; k <= int'(TIMEOUT) + 3; k++) begin
            step();
            check("timeout_err", 32'(err), 32'(k >= int'(TIMEOUT)));
            check("timeout_devB", 32'(devB), 32'd1);
        end
        devA = 1'b0;
        step();
        check("recover_devB", 32'(devB), 32'd0);
        check("recover_err", 32'(err), 32'd1);

        // Reset in the middle of a handshake
        reset = 1'b0;
        step();
        reset = 1'b1;
        hs(8'h21);
        devA    = 1'b1;
        data_in = 8'h22;
        step();
        check("mid_level", 32'(level), 32'd2);
        reset = 1'b0;
        step();
        check("mid_devB", 32'(devB), 32'd0);
        check("mid_level0", 32'(level), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        reset = 1'b1;
        devA  = 1'b0;
        step();

        // Randomized requester and consumer
        hold_target = 0;
        held        = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) != 0);
            if ((($urandom_range(0, 199)) == 0) || (c % 400 < 40)) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
            if (!devA && !devB) begin
                if ($urandom_range(0, 1) == 1) begin
                    devA        = 1'b1;
                    data_in     = 8'($urandom);
                    held        = 0;
                    hold_target = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 25)
                                                              : $urandom_range(0, 2);
                end
            end else if (devA && devB) begin
                if (held >= hold_target) devA = 1'b0;
                held++;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
